// File: rtl/mem_responder.sv
// mem_responder: single-port 32-bit data memory with a fixed, parameterised
// access latency and a pipeline-hold handshake.
//
// An access is accepted in IDLE. The FSM then spends WAIT_CYCLES cycles in
// WAIT and one cycle in DONE. Writes are committed on the edge that enters
// DONE. Reads are loaded into ReadData on the same edge.
//
// Ports
//   Clk        in   clock, rising edge
//   Reset      in   asynchronous, active-low reset
//   MemRead    in   read request
//   MemWrite   in   write request (wins when both request lines are high)
//   Address    in   byte address; bits above the array size are ignored
//   WriteData  in   store data; byte/half stores use the low bits
//   Size       in   00 word, 01 half, 10 byte, 11 treated as word
//   Stall      out  hold: request seen in IDLE, or access in WAIT
//   Done       out  one-cycle completion pulse
//   ReadData   out  last completed read, low-aligned and zero-extended
//   Err        out  pulses with Done for misaligned or read+write requests
module mem_responder #(
    parameter int WAIT_CYCLES = 2,
    parameter int DEPTH       = 128
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic [1:0]  Size,
    output logic        Stall,
    output logic        Done,
    output logic [31:0] ReadData,
    output logic        Err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t      state, state_next;
    logic [3:0]  count, count_next;

    // Request captured at acceptance
    logic [AW+1:0] cap_addr;
    logic [31:0]   cap_wdata;
    logic [1:0]    cap_size;
    logic          cap_write;
    logic          cap_conflict;

    // Access currently being served: live inputs while in IDLE (this also
    // covers the zero-wait case, where the access completes on the
    // acceptance edge), captured copy afterwards.
    logic [AW+1:0] acc_addr;
    logic [31:0]   acc_wdata;
    logic [1:0]    acc_size;
    logic          acc_write;
    logic          acc_conflict;
    logic          is_half, is_byte, misaligned;

    logic          req, enter_done, commit_write, load_read;
    logic [AW-1:0] word_idx;
    logic [31:0]   mem_word, merged_word, read_value;
    logic          addr_unused;

    logic [31:0]   mem [DEPTH];

    assign addr_unused = ^Address[31:AW+2];
    assign req         = MemRead | MemWrite;

    always_comb begin
        if (state == IDLE) begin
            acc_addr     = Address[AW+1:0];
            acc_wdata    = WriteData;
            acc_size     = Size;
            acc_write    = MemWrite;
            acc_conflict = MemRead & MemWrite;
        end else begin
            acc_addr     = cap_addr;
            acc_wdata    = cap_wdata;
            acc_size     = cap_size;
            acc_write    = cap_write;
            acc_conflict = cap_conflict;
        end
    end

    assign is_half    = (acc_size == 2'b01);
    assign is_byte    = (acc_size == 2'b10);
    assign misaligned = is_half ? acc_addr[0] : (!is_byte && (acc_addr[1:0] != 2'b00));
    assign word_idx   = acc_addr[AW+1:2];
    assign mem_word   = mem[word_idx];

    // Read-modify-write so narrow stores touch only their own lane
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        merged_word = acc_wdata;
        if (is_byte) begin
            merged_word = mem_word;
            merged_word[{acc_addr[1:0], 3'b000} +: 8] = acc_wdata[7:0];
        end else if (is_half) begin
            merged_word = mem_word;
            merged_word[{acc_addr[1], 4'b0000} +: 16] = acc_wdata[15:0];
        end
    end

    always_comb begin
        read_value = mem_word;
        if (is_byte)
            read_value = {24'b0, mem_word[{acc_addr[1:0], 3'b000} +: 8]};
        else if (is_half)
            read_value = {16'b0, mem_word[{acc_addr[1], 4'b0000} +: 16]};
    end

    // Next state and the FSM-driven outputs
    always_comb begin
        state_next = state;
        count_next = count;
        Stall      = 1'b0;
        Done       = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    Stall = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_next = DONE;
                    end else begin
                        state_next = WAIT;
                        count_next = WAIT_INIT;
                    end
                end
            end
            WAIT: begin
                Stall      = 1'b1;
                count_next = count - 4'd1;
                if (count == 4'd1)
                    state_next = DONE;
            end
            DONE: begin
                Done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign Err          = (state == DONE) && (acc_conflict || misaligned);
    assign enter_done   = (state_next == DONE) && (state != DONE);
    assign commit_write = enter_done && acc_write && !misaligned;
    assign load_read    = enter_done && !acc_write && !misaligned;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state        <= IDLE;
            count        <= '0;
            cap_addr     <= '0;
            cap_wdata    <= '0;
            cap_size     <= '0;
            cap_write    <= 1'b0;
            cap_conflict <= 1'b0;
            ReadData     <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples the pre-edge values, independent of block order.
            state <= state_next;
            count <= count_next;
            if (state == IDLE && req) begin
                cap_addr     <= Address[AW+1:0];
                cap_wdata    <= WriteData;
                cap_size     <= Size;
                cap_write    <= MemWrite;
                cap_conflict <= MemRead & MemWrite;
            end
            if (load_read)
                ReadData <= read_value;
        end
    end

    // NOTE: the array has no reset so its contents survive Reset; the write
    // enable is still gated by Reset so a zero-wait access cannot commit
    // while reset is held.
    always_ff @(posedge Clk) begin
        if (commit_write && Reset)
            mem[word_idx] <= merged_word;
    end

endmodule

// File: tb/tb_mem_responder.sv
// Testbench for mem_responder. A transaction-level model, based on timestamps,
// predicts Stall/Done/Err/ReadData every cycle for the WAIT_CYCLES=2 instance.
// A second instance with WAIT_CYCLES=0 is checked against hand-derived
// literal sequences.
module tb_mem_responder;

    localparam int W     = 2;
    localparam int DEPTH = 128;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_read, mem_write;
    logic [31:0] address, write_data;
    logic [1:0]  size;
    logic        stall, done, err;
    logic [31:0] rdata;

    logic        d0_read, d0_write;
    logic        stall0, done0, err0;
    logic [31:0] rdata0;

    always #5 clk = ~clk;

    mem_responder #(.WAIT_CYCLES(W), .DEPTH(DEPTH)) dut (
        .Clk(clk), .Reset(rst_n), .MemRead(mem_read), .MemWrite(mem_write),
        .Address(address), .WriteData(write_data), .Size(size),
        .Stall(stall), .Done(done), .ReadData(rdata), .Err(err)
    );

    mem_responder #(.WAIT_CYCLES(0), .DEPTH(DEPTH)) dut0 (
        .Clk(clk), .Reset(rst_n), .MemRead(d0_read), .MemWrite(d0_write),
        .Address(address), .WriteData(write_data), .Size(size),
        .Stall(stall0), .Done(done0), .ReadData(rdata0), .Err(err0)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit [31:0]   m_mem [DEPTH];
    bit [31:0]   m_rd = 0;
    bit          m_busy = 0;
    int unsigned cyc = 0;
    int unsigned m_done_cyc = 0;
    bit          t_rd, t_wr;
    bit [31:0]   t_addr, t_data;
    bit [1:0]    t_size;

    function automatic bit is_mis(input bit [1:0] sz, input bit [31:0] a);
        if (sz == 2'b01) return a[0];
        if (sz == 2'b10) return 1'b0;
        return a[1:0] != 2'b00;
    endfunction

    task automatic model_commit();
        int idx;
        int lane;
        idx  = int'((t_addr >> 2) % DEPTH);
        lane = int'(t_addr[1:0]);
        if (!is_mis(t_size, t_addr)) begin
            if (t_wr) begin
                if (t_size == 2'b10)      m_mem[idx][lane*8 +: 8]  = t_data[7:0];
                else if (t_size == 2'b01) m_mem[idx][lane*8 +: 16] = t_data[15:0];
                else                      m_mem[idx] = t_data;
            end else begin
                if (t_size == 2'b10)      m_rd = (m_mem[idx] >> (8*lane)) & 32'hFF;
                else if (t_size == 2'b01) m_rd = (m_mem[idx] >> (8*lane)) & 32'hFFFF;
                else                      m_rd = m_mem[idx];
            end
        end
    endtask

    // An access accepted at edge N is served for W cycles and completes in
    // the cycle indexed N+W. The responder is free again after that cycle.
    initial begin
        int unsigned prev;
        forever begin
            @(posedge clk);
            prev = cyc;
            cyc  = cyc + 1;
            if (!rst_n) begin
                m_busy = 0;
                m_rd   = 0;
            end else begin
                if ((!m_busy || prev > m_done_cyc) && (mem_read || mem_write)) begin
                    m_busy     = 1;
                    t_rd       = mem_read;
                    t_wr       = mem_write;
                    t_addr     = address;
                    t_data     = write_data;
                    t_size     = size;
                    m_done_cyc = cyc + W;
                end
                if (m_busy && m_done_cyc == cyc) model_commit();
            end
        end
    end

    // Compare process: every falling edge, for the W=2 instance
    initial begin
        bit        exp_stall, exp_done, exp_err, active;
        bit [31:0] exp_rd;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_stall = mem_read | mem_write;
                exp_done  = 0;
                exp_err   = 0;
                exp_rd    = 0;
            end else begin
                active    = m_busy && cyc <= m_done_cyc;
                exp_done  = m_busy && cyc == m_done_cyc;
                exp_stall = (m_busy && cyc < m_done_cyc) || (!active && (mem_read || mem_write));
                exp_err   = exp_done && (is_mis(t_size, t_addr) || (t_rd && t_wr));
                exp_rd    = m_rd;
            end
            check("stall", {31'b0, stall}, {31'b0, exp_stall});
            check("done",  {31'b0, done},  {31'b0, exp_done});
            check("err",   {31'b0, err},   {31'b0, exp_err});
            check("rdata", rdata, exp_rd);
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit rd, input bit wr, input bit [31:0] a, input bit [31:0] d,
                         input bit [1:0] sz);
        mem_read   = rd;
        mem_write  = wr;
        address    = a;
        write_data = d;
        size       = sz;
    endtask

    // Entered and left at posedge+1 while the responder is idle
    task automatic do_access(input bit rd, input bit wr, input bit [31:0] a, input bit [31:0] d,
                             input bit [1:0] sz, output int lat, output int stalls,
                             output bit err_seen);
        lat = 0; stalls = 0; err_seen = 0;
        drive(rd, wr, a, d, sz);
        @(negedge clk);
        if (stall) stalls++;
        @(posedge clk); #1;
        drive(0, 0, a, d, sz);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (stall) stalls++;
            if (done) begin
                lat = i + 1;
                err_seen = err;
                break;
            end
        end
        if (lat == 0) check("done_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic acc_chk(input string name, input bit rd, input bit wr, input bit [31:0] a,
                           input bit [31:0] d, input bit [1:0] sz, input bit exp_err);
        int lat, stalls;
        bit e;
        do_access(rd, wr, a, d, sz, lat, stalls, e);
        check({name, "_lat"},    lat,    W + 1);
        check({name, "_stalls"}, stalls, W + 1);
        check({name, "_err"},    {31'b0, e}, {31'b0, exp_err});
    endtask

    task automatic rd_chk(input string name, input bit [31:0] a, input bit [1:0] sz,
                          input bit [31:0] lit, input bit exp_err);
        acc_chk(name, 1, 0, a, 0, sz, exp_err);
        check({name, "_rdata"}, rdata, lit);
        check({name, "_model"}, m_rd,  lit);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dn, rst_cnt, r;
        bit [31:0] a;
        bit [1:0]  sz;
        rst_n = 1;
        drive(0, 0, 0, 0, 0);
        d0_read = 0;
        d0_write = 0;
        #1 rst_n = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rdata", rdata, 32'h0);
        check("reset_done",  {31'b0, done},  32'h0);
        check("reset_stall", {31'b0, stall}, 32'h0);
        rst_n = 1;

        // Zero-wait instance: single request, then a held request
        d0_write = 1; drive(0, 0, 32'h0, 32'h1, 2'b00);
        @(negedge clk);
        check("w0_req_stall", {31'b0, stall0}, 32'd1);
        check("w0_req_done",  {31'b0, done0},  32'd0);
        @(posedge clk); #1 d0_write = 0;
        @(negedge clk);
        check("w0_done",       {31'b0, done0},  32'd1);
        check("w0_done_stall", {31'b0, stall0}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("w0_idle_done", {31'b0, done0}, 32'd0);
        @(posedge clk); #1 d0_write = 1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("w0_held_done",  {31'b0, done0},  {31'b0, i[0]});
            check("w0_held_stall", {31'b0, stall0}, {31'b0, ~i[0]});
        end
        @(posedge clk); #1 d0_write = 0;
        check("w0_rdata", rdata0, 32'h0);

        // Fill the array so every later read is defined
        for (int i = 0; i < DEPTH; i++) begin
            int lat, stalls;
            bit e;
            do_access(0, 1, i * 4, $urandom, 2'b00, lat, stalls, e);
        end

        acc_chk("wr_deadbeef", 0, 1, 32'h10, 32'hDEADBEEF, 2'b00, 0);
        rd_chk("rd_deadbeef", 32'h10, 2'b00, 32'hDEADBEEF, 0);
        acc_chk("wr_11223344", 0, 1, 32'h10, 32'h11223344, 2'b00, 0);
        acc_chk("wr_byte",     0, 1, 32'h13, 32'h000000AA, 2'b10, 0);
        rd_chk("rd_word_aa", 32'h10, 2'b00, 32'hAA223344, 0);
        rd_chk("rd_byte_aa", 32'h13, 2'b10, 32'h000000AA, 0);
        rd_chk("rd_half_aa", 32'h12, 2'b01, 32'h0000AA22, 0);
        rd_chk("rd_misalign", 32'h06, 2'b00, 32'h0000AA22, 1);
        acc_chk("wr_half_mis", 0, 1, 32'h11, 32'h0000FFFF, 2'b01, 1);
        rd_chk("rd_after_mis", 32'h10, 2'b00, 32'hAA223344, 0);
        acc_chk("wr_conflict", 1, 1, 32'h20, 32'h00000005, 2'b00, 1);
        rd_chk("rd_conflict", 32'h20, 2'b00, 32'h00000005, 0);
        rd_chk("rd_wrap", 32'h220, 2'b00, 32'h00000005, 0);

        // Reset in the middle of a write
        acc_chk("wr_cafe", 0, 1, 32'h30, 32'hCAFEF00D, 2'b00, 0);
        drive(0, 1, 32'h30, 32'h12345678, 2'b00);
        @(posedge clk); #1 drive(0, 0, 32'h30, 32'h12345678, 2'b00);
        rst_n = 0;
        dn = 0;
        repeat (3) begin @(negedge clk); dn += int'(done); end
        @(posedge clk); #1 rst_n = 1;
        repeat (4) begin @(negedge clk); dn += int'(done); end
        check("rst_mid_done", dn, 0);
        @(posedge clk); #1;
        rd_chk("rd_after_rst", 32'h30, 2'b00, 32'hCAFEF00D, 0);

        // Random traffic, including held requests and occasional resets
        rst_cnt = 0;
        for (int n = 0; n < 2500; n++) begin
            r  = int'($urandom_range(0, 99));
            sz = 2'($urandom_range(0, 3));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'b01)      a[0]   = 1'b0;
                else if (sz != 2'b10) a[1:0] = 2'b00;
            end
            drive(r < 30, r >= 25 && r < 55, a, $urandom, sz);
            if (rst_cnt > 0) begin
                rst_cnt--;
                if (rst_cnt == 0) rst_n = 1;
            end else if ($urandom_range(0, 299) == 0) begin
                rst_n   = 0;
                rst_cnt = 2;
            end
            @(posedge clk); #1;
        end
        rst_n = 1;
        drive(0, 0, 0, 0, 0);
        repeat (W + 4) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, extra wait-state cycles per access (range 0-15).
REQ-002 Parameter DEPTH, default 128, number of 32-bit memory words (power of two).
REQ-003 Clk  input  1  single clock; all state updates on rising edge.
REQ-004 Reset  input  1  asynchronous, active-low reset.
REQ-005 MemRead  input  1  read request.
REQ-006 MemWrite  input  1  write request.
REQ-007 Address  input  32  byte address.
REQ-008 WriteData  input  32  store data; byte/half taken from low bits.
REQ-009 Size  input  2  00 word, 01 half, 10 byte, 11 reserved (treated as word).
REQ-010 Stall  output  1  pipeline hold; high while an access is pending.
REQ-011 Done  output  1  one-cycle pulse marking access completion.
REQ-012 ReadData  output  32  read result, low-aligned, upper bits zero for half/byte.
REQ-013 Err  output  1  one-cycle pulse with Done for misaligned or conflicting request.

Function
REQ-014 FSM states SHALL be IDLE, WAIT, DONE.
REQ-015 IDLE: MemRead or MemWrite high -> capture Address, WriteData, Size, operation; go WAIT with counter=WAIT_CYCLES, or DONE directly if WAIT_CYCLES=0.
REQ-016 WAIT: counter decrements each cycle; at counter=1 go DONE.
REQ-017 DONE: Done=1 for exactly one cycle, then IDLE unconditionally.
REQ-018 Latency: request sampled at edge N -> Done high during cycle N+1+WAIT_CYCLES.
REQ-019 Stall SHALL be combinational: 1 when (IDLE and request present) or state=WAIT; 0 in DONE and idle-without-request.
REQ-020 Requests present during WAIT or DONE SHALL be ignored; a held request is re-accepted only in IDLE.
REQ-021 Word index = Address[2+log2(DEPTH)-1:2]; higher address bits ignored (wrap-around).
REQ-022 Byte lane = Address[1:0]; half lane = Address[1].
REQ-023 Write commit SHALL occur on the edge entering DONE; byte/half writes modify only the addressed lane.
REQ-024 Read data SHALL be loaded into ReadData on the edge entering DONE and held until the next completed read.
REQ-025 Misaligned (word with Address[1:0]!=0, half with Address[0]=1): no memory write, ReadData unchanged, Err=1 with Done.
REQ-026 MemRead and MemWrite both high: performed as write, Err=1 with Done.
REQ-027 Writes SHALL never affect ReadData.

Reset
REQ-028 Reset low SHALL immediately force state IDLE, counter 0, Stall per REQ-019, Done=0, Err=0, ReadData=0.
REQ-029 Reset mid-access SHALL discard the pending access; no memory write occurs.
REQ-030 Memory array contents SHALL NOT be altered by reset.
REQ-031 After Reset deasserts, first request accepted on the next rising edge.

Verification
REQ-032 Word write 0xDEADBEEF @0x10, then word read @0x10 (WAIT_CYCLES=2) -> Stall high 3 cycles each, Done in cycle N+3, ReadData=0xDEADBEEF, Err=0.
REQ-033 Byte write 0xAA @0x13 over 0x11223344, word read @0x10 -> 0xAA223344; byte read @0x13 -> 0x000000AA; half read @0x12 -> 0x0000AA22.
REQ-034 Word read @0x06 -> Err=1 with Done, ReadData unchanged; half write @0x11 -> memory unchanged, Err=1.
REQ-035 MemRead=MemWrite=1, word @0x20 data 0x5 -> word written, Err=1; subsequent read @0x20 -> 0x00000005; read @0x220 (DEPTH=128) -> 0x00000005 (wrap).
REQ-036 Reset low during WAIT of word write 0x12345678 @0x30 -> state IDLE, Done never pulses, read @0x30 returns prior value.
REQ-037 WAIT_CYCLES=0 build: request at edge N -> Done during cycle N+1, Stall high exactly 1 cycle; request held continuously -> Done every 2 cycles.
